ddr_local_wb_bridge: RTL and testbench
======================================

DDR_LOCAL_WB_BRIDGE -- requirements
Module: ddr_local_wb_bridge

Interface
REQ-001 Parameter RD_TIMEOUT, default 255: maximum number of cycles a read waits for local_rdata_valid before wb_err_o is raised; legal range 1..255.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 wb_adr_i  in  32  Wishbone byte address; bits [24:2] are used, all other bits are ignored.
REQ-005 wb_dat_i / wb_sel_i  in  32 / 4  Wishbone write data and byte selects.
REQ-006 wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  Wishbone write enable, cycle, strobe.
REQ-007 wb_dat_o  out  32  Wishbone read data.
REQ-008 wb_ack_o, wb_err_o  out  1 each  Wishbone acknowledge and error, each a single-cycle pulse.
REQ-009 local_ready  in  1  controller accepts the presented request at this edge.
REQ-010 local_rdata / local_rdata_valid  in  32 / 1  controller read data and its qualifier.
REQ-011 local_init_done  in  1  controller calibration and initialisation complete.
REQ-012 local_read_req, local_write_req, local_burstbegin  out  1 each  request strobes to the controller.
REQ-013 local_size  out  2  burst size; held at constant 2'd1.
REQ-014 local_cs_addr  out  1  held at constant 0.
REQ-015 local_row_addr / local_bank_addr / local_col_addr  out  13 / 2 / 8  decoded memory address.
REQ-016 local_wdata / local_be  out  32 / 4  write data and byte enables (Avalon mode: presented together with write_req).
REQ-017 local_autopch_req  out  1  held at constant 0.

Function
REQ-018 Address decode: col = wb_adr_i[9:2], bank = wb_adr_i[11:10], row = wb_adr_i[24:12]; all address outputs are registered when a request is launched.
REQ-019 States: IDLE, WR_REQ, RD_REQ, RD_WAIT, ACK.
REQ-020 IDLE: on wb_cyc_i & wb_stb_i & local_init_done, latch address, data and sel, then go to WR_REQ if wb_we_i is 1, else RD_REQ. While local_init_done is 0, no request is launched and the Wishbone cycle stalls.
REQ-021 WR_REQ: local_write_req = 1, with local_wdata = latched data and local_be = latched sel. Hold all request outputs stable until a clock edge with local_ready = 1, then go to ACK.
REQ-022 RD_REQ: local_read_req = 1, held stable until an edge with local_ready = 1, then go to RD_WAIT with the timeout counter cleared.
REQ-023 local_burstbegin is 1 only in the first cycle of each WR_REQ/RD_REQ entry and stays 0 during any further cycles of the same request.
REQ-024 RD_WAIT: on local_rdata_valid = 1, register local_rdata into wb_dat_o and go to ACK. Otherwise increment the 8-bit counter.
REQ-025 Read timeout: when the counter equals RD_TIMEOUT without valid data, pulse wb_err_o for one cycle, set a discard flag, and return to IDLE.
REQ-026 Discard flag: the next local_rdata_valid received while the flag is set is dropped (no ack, wb_dat_o unchanged) and clears the flag. A new read may launch while the flag is set; its first valid beat is the one dropped.
REQ-027 ACK: wb_ack_o = 1 for exactly one cycle, then IDLE. The minimum write latency is 2 cycles from strobe to ack when local_ready = 1 immediately.
REQ-028 If wb_cyc_i drops after a request is launched, the local request still completes, no wb_ack_o or wb_err_o is issued, and read data is discarded.
REQ-029 local_rdata_valid arriving in IDLE, WR_REQ or RD_REQ with the discard flag clear is ignored.
REQ-030 At most one local request is outstanding, except for a timed-out read covered by the discard flag.

Reset
REQ-031 Assertion of reset_n = 0 immediately forces: state IDLE; all local_*_req, local_burstbegin, wb_ack_o and wb_err_o = 0; wb_dat_o, local_wdata, local_be and address outputs = 0; counter = 0; discard flag = 0.
REQ-032 Reset in mid-transaction abandons the transaction with no ack. The controller is assumed to be reset by the same reset_n.

Verification
REQ-033 Write adr 0x0000_1C08, dat 0xDEADBEEF, sel 4'hF, local_ready = 1 -> write_req and burstbegin for 1 cycle; row 1, bank 3, col 2; wb_ack 1 cycle later.
REQ-034 Read with local_ready low for 3 cycles, then rdata 0x12345678 valid 5 cycles after accept -> read_req held 4 cycles, burstbegin only in the first; wb_dat_o = 0x12345678 with a single ack.
REQ-035 local_init_done = 0 with a strobe pending for 10 cycles -> no local requests; after init_done rises, the request issues on the next cycle.
REQ-036 RD_TIMEOUT = 4, read accepted, valid never arrives -> wb_err_o pulses 4 cycles after accept. A late valid 0xAAAA5555 is then dropped, and the following read returns its own data, 0x0BADF00D.
REQ-037 wb_cyc_i drops during RD_WAIT -> the later valid produces no ack. Also check reset asserted during WR_REQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/ddr_local_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ddr_local_wb_bridge
// Description : Wishbone slave to DDR controller local (Avalon-style) port
//               bridge. Issues one single-beat local request per Wishbone
//               cycle, decodes the byte address into row/bank/col, and
//               times out reads that never return data.
// Ports       : clk, reset_n            - clock, async active-low reset
//               wb_*                    - Wishbone slave (adr/dat/sel/we/
//                                         cyc/stb in, dat/ack/err out)
//               local_ready/rdata/
//               rdata_valid/init_done   - controller status and read data
//               local_*_req, burstbegin,
//               size, addresses, wdata,
//               be, autopch_req         - controller request outputs
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_local_wb_bridge #(
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic        local_ready,
    input  logic [31:0] local_rdata,
    input  logic        local_rdata_valid,
    input  logic        local_init_done,
    output logic        local_read_req,
    output logic        local_write_req,
    output logic        local_burstbegin,
    output logic [1:0]  local_size,
    output logic        local_cs_addr,
    output logic [12:0] local_row_addr,
    output logic [1:0]  local_bank_addr,
    output logic [7:0]  local_col_addr,
    output logic [31:0] local_wdata,
    output logic [3:0]  local_be,
    output logic        local_autopch_req
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    localparam logic [7:0] c_rd_timeout = 8'(RD_TIMEOUT);

    state_t     r_state;
    logic [7:0] r_rd_cnt;
    logic       r_discard;   // a timed-out read beat is still owed by the controller
    logic       r_abort;     // master abandoned the cycle; finish locally, answer nothing

    logic       w_launch;
    logic       w_cyc_lost;
    logic       w_drop_beat;
    logic       w_own_beat;
    logic [7:0] w_cnt_next;
    logic       w_unused;

    // No launch while an error is on the bus: the master only sees it at the
    // end of that cycle, so its strobe is still up for one more edge.
    assign w_launch    = wb_cyc_i & wb_stb_i & local_init_done & ~wb_err_o;
    assign w_cyc_lost  = r_abort | ~wb_cyc_i;
    assign w_drop_beat = local_rdata_valid & r_discard;
    assign w_own_beat  = local_rdata_valid & ~r_discard;
    assign w_cnt_next  = r_rd_cnt + 8'd1;

    assign local_size        = 2'd1;
    assign local_cs_addr     = 1'b0;
    assign local_autopch_req = 1'b0;

    assign w_unused = ^{wb_adr_i[31:25], wb_adr_i[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_rd_cnt         <= 8'd0;
            r_discard        <= 1'b0;
            r_abort          <= 1'b0;
            wb_dat_o         <= 32'd0;
            wb_ack_o         <= 1'b0;
            wb_err_o         <= 1'b0;
            local_read_req   <= 1'b0;
            local_write_req  <= 1'b0;
            local_burstbegin <= 1'b0;
            local_row_addr   <= 13'd0;
            local_bank_addr  <= 2'd0;
            local_col_addr   <= 8'd0;
            local_wdata      <= 32'd0;
            local_be         <= 4'd0;
        end else begin
            // Pulses default low; burstbegin only survives its entry cycle.
            local_burstbegin <= 1'b0;
            wb_ack_o         <= 1'b0;
            wb_err_o         <= 1'b0;

            // The stale beat is absorbed in whatever state it shows up.
            if (w_drop_beat) begin
                r_discard <= 1'b0;
            end

            if (r_state == ST_IDLE) begin
                r_abort <= 1'b0;
            end else if (!wb_cyc_i) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        local_col_addr   <= wb_adr_i[9:2];
                        local_bank_addr  <= wb_adr_i[11:10];
                        local_row_addr   <= wb_adr_i[24:12];
                        local_wdata      <= wb_dat_i;
                        local_be         <= wb_sel_i;
                        local_burstbegin <= 1'b1;
                        if (wb_we_i) begin
                            local_write_req <= 1'b1;
                            r_state         <= ST_WR_REQ;
                        end else begin
                            local_read_req <= 1'b1;
                            r_state        <= ST_RD_REQ;
                        end
                    end
                end

                ST_WR_REQ: begin
                    if (local_ready) begin
                        local_write_req <= 1'b0;
                        if (w_cyc_lost) begin
                            r_state <= ST_IDLE;
                        end else begin
                            wb_ack_o <= 1'b1;
                            r_state  <= ST_ACK;
                        end
                    end
                end

                ST_RD_REQ: begin
                    if (local_ready) begin
                        local_read_req <= 1'b0;
                        r_rd_cnt       <= 8'd0;
                        r_state        <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (w_own_beat) begin
                        if (w_cyc_lost) begin
                            r_state <= ST_IDLE;
                        end else begin
                            wb_dat_o <= local_rdata;
                            wb_ack_o <= 1'b1;
                            r_state  <= ST_ACK;
                        end
                    end else if (w_cnt_next == c_rd_timeout) begin
                        // Overrides a same-cycle clear: this read's beat is now owed.
                        r_discard <= 1'b1;
                        wb_err_o  <= ~w_cyc_lost;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_rd_cnt <= w_cnt_next;
                    end
                end

                ST_ACK: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_local_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_local_wb_bridge
// Description : Self-checking bench for ddr_local_wb_bridge. Instance A uses
//               the default read timeout, instance B a timeout of 4; a select
//               line routes the Wishbone cycle to one of them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_local_wb_bridge;

    typedef struct packed {
        logic [31:0] dat;
        logic        ack;
        logic        err;
        logic        rreq;
        logic        wreq;
        logic        bb;
        logic [1:0]  size;
        logic        cs;
        logic [12:0] row;
        logic [1:0]  bank;
        logic [7:0]  col;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        apch;
    } obs_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          rdy;
        int          vld;
        logic [31:0] rdata;
        logic [12:0] row;
        logic [1:0]  bank;
        logic [7:0]  col;
        int          ack_cyc;
        int          req_cyc;
        logic [31:0] dat_o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] wb_adr_i, wb_dat_i, local_rdata;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic        local_ready, local_rdata_valid, local_init_done;
    logic        sel_b;
    logic        cyc_a, stb_a, cyc_b, stb_b;
    obs_t        oa, ob, o;

    assign cyc_a = wb_cyc_i & ~sel_b;
    assign stb_a = wb_stb_i & ~sel_b;
    assign cyc_b = wb_cyc_i & sel_b;
    assign stb_b = wb_stb_i & sel_b;
    assign o     = sel_b ? ob : oa;

    always #5 clk = ~clk;

    ddr_local_wb_bridge u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(cyc_a), .wb_stb_i(stb_a),
        .wb_dat_o(oa.dat), .wb_ack_o(oa.ack), .wb_err_o(oa.err),
        .local_ready(local_ready), .local_rdata(local_rdata),
        .local_rdata_valid(local_rdata_valid), .local_init_done(local_init_done),
        .local_read_req(oa.rreq), .local_write_req(oa.wreq), .local_burstbegin(oa.bb),
        .local_size(oa.size), .local_cs_addr(oa.cs), .local_row_addr(oa.row),
        .local_bank_addr(oa.bank), .local_col_addr(oa.col), .local_wdata(oa.wdata),
        .local_be(oa.be), .local_autopch_req(oa.apch)
    );

    ddr_local_wb_bridge #(.RD_TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(cyc_b), .wb_stb_i(stb_b),
        .wb_dat_o(ob.dat), .wb_ack_o(ob.ack), .wb_err_o(ob.err),
        .local_ready(local_ready), .local_rdata(local_rdata),
        .local_rdata_valid(local_rdata_valid), .local_init_done(local_init_done),
        .local_read_req(ob.rreq), .local_write_req(ob.wreq), .local_burstbegin(ob.bb),
        .local_size(ob.size), .local_cs_addr(ob.cs), .local_row_addr(ob.row),
        .local_bank_addr(ob.bank), .local_col_addr(ob.col), .local_wdata(ob.wdata),
        .local_be(ob.be), .local_autopch_req(ob.apch)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Results of the last run_txn
    int          r_req, r_bb, r_ack_cyc, r_acks, r_errs, r_err_cyc;
    logic        r_stable;
    obs_t        r_first;
    logic [31:0] r_dat;

    // One Wishbone transaction as seen from the master and a controller
    // model. Called and returns at a negedge. Cycle k is the interval after
    // the k-th rising edge counted from the launch edge (edge 0).
    // vld/extra: edges after the accept edge at which the real beat and an
    // extra 0xAAAA5555 beat arrive (0 = never / none).
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int rdy, input int vld,
                           input logic [31:0] rdata, input int extra);
        int acc_edge;
        int end_cyc;
        acc_edge  = -1;
        end_cyc   = 40;
        r_req     = 0; r_bb = 0; r_acks = 0; r_errs = 0;
        r_ack_cyc = -1; r_err_cyc = -1; r_stable = 1'b1;
        r_first   = '0; r_dat = 32'd0;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        local_ready = 1'b0; local_rdata_valid = 1'b0;
        for (int k = 1; k <= end_cyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            local_ready       = 1'b0;
            local_rdata_valid = 1'b0;
            local_rdata       = $urandom;
            if (we ? o.wreq : o.rreq) begin
                if (r_req == 0) r_first = o;
                else if ({o.wreq, o.rreq, o.row, o.bank, o.col, o.wdata, o.be} !==
                         {r_first.wreq, r_first.rreq, r_first.row, r_first.bank,
                          r_first.col, r_first.wdata, r_first.be})
                    r_stable = 1'b0;
                r_req++;
                if (r_req == rdy + 1) begin
                    local_ready = 1'b1;
                    acc_edge    = k + 1;
                end
            end
            if (o.bb) r_bb++;
            if (o.ack) begin
                r_acks++;
                if (r_ack_cyc < 0) begin r_ack_cyc = k; r_dat = o.dat; end
            end
            if (o.err) begin
                r_errs++;
                if (r_err_cyc < 0) r_err_cyc = k;
            end
            if (o.ack || o.err) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
                if (end_cyc > k + 2) end_cyc = k + 2;
            end
            if (!we && acc_edge > 0) begin
                if (vld > 0 && k + 1 == acc_edge + vld) begin
                    local_rdata_valid = 1'b1; local_rdata = rdata;
                end else if (extra > 0 && k + 1 == acc_edge + extra) begin
                    local_rdata_valid = 1'b1; local_rdata = 32'hAAAA5555;
                end
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        local_ready = 1'b0; local_rdata_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    vec_t        vecs[4];
    logic [31:0] exp_dat_a;
    obs_t        rst_exp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_1C08, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,
                    13'd1, 2'd3, 8'd2, 2, 1, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_2410, 32'h0, 4'hF, 3, 5, 32'h12345678,
                    13'd2, 2'd1, 8'd4, 10, 4, 32'h12345678};
        vecs[2] = '{1'b1, 32'hFE01_FFFC, 32'h0102_0304, 4'h5, 1, 0, 32'h0,
                    13'h01F, 2'd3, 8'hFF, 3, 2, 32'h12345678};
        vecs[3] = '{1'b0, 32'h01FF_F000, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D,
                    13'h1FFF, 2'd0, 8'd0, 3, 1, 32'hCAFEF00D};

        reset_n = 1'b0; sel_b = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        local_ready = 1'b0; local_rdata = '0; local_rdata_valid = 1'b0;
        local_init_done = 1'b1;
        rst_exp = '0;
        rst_exp.size = 2'd1;

        step(2);
        check("reset_state_a", oa, rst_exp);
        check("reset_state_b", ob, rst_exp);
        reset_n = 1'b1;
        step(1);

        // ---- table-driven directed vectors (instance A) ----
        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                    vecs[i].rdy, vecs[i].vld, vecs[i].rdata, 0);
            check($sformatf("vec%0d_row", i), r_first.row, vecs[i].row);
            check($sformatf("vec%0d_bank", i), r_first.bank, vecs[i].bank);
            check($sformatf("vec%0d_col", i), r_first.col, vecs[i].col);
            check($sformatf("vec%0d_req_cycles", i), r_req, vecs[i].req_cyc);
            check($sformatf("vec%0d_burstbegin", i), r_bb, 1);
            check($sformatf("vec%0d_ack_cycle", i), r_ack_cyc, vecs[i].ack_cyc);
            check($sformatf("vec%0d_ack_count", i), r_acks, 1);
            check($sformatf("vec%0d_err_count", i), r_errs, 0);
            check($sformatf("vec%0d_dat_o", i), r_dat, vecs[i].dat_o);
            check($sformatf("vec%0d_stable", i), r_stable, 1'b1);
            if (vecs[i].we) begin
                check($sformatf("vec%0d_wdata", i), r_first.wdata, vecs[i].dat);
                check($sformatf("vec%0d_be", i), r_first.be, vecs[i].sel);
            end
        end
        exp_dat_a = 32'hCAFEF00D;

        // ---- randomized transactions vs transaction-level model ----
        for (int i = 0; i < 24; i++) begin
            logic        we;
            logic [31:0] adr, dat, rdata;
            logic [3:0]  sel;
            int          rdy, vld;
            we = 1'($urandom_range(0, 1));
            adr = $urandom; dat = $urandom; rdata = $urandom;
            sel = 4'($urandom_range(0, 15));
            rdy = $urandom_range(0, 4);
            vld = $urandom_range(1, 6);
            run_txn(we, adr, dat, sel, rdy, vld, rdata, 0);
            if (!we) exp_dat_a = rdata;
            check($sformatf("rnd%0d_addr", i), {r_first.row, r_first.bank, r_first.col},
                  {13'((adr / 4096) % 8192), 2'((adr / 1024) % 4), 8'((adr / 4) % 256)});
            check($sformatf("rnd%0d_req_cycles", i), r_req, rdy + 1);
            check($sformatf("rnd%0d_ack_cycle", i), r_ack_cyc, we ? rdy + 2 : rdy + 2 + vld);
            check($sformatf("rnd%0d_counts", i), {r_acks[7:0], r_errs[7:0], r_bb[7:0]},
                  {8'd1, 8'd0, 8'd1});
            check($sformatf("rnd%0d_dat_o", i), r_dat, exp_dat_a);
            if (we) check($sformatf("rnd%0d_wdata_be", i), {r_first.wdata, r_first.be}, {dat, sel});
        end

        // ---- init_done low stalls the cycle ----
        begin
            int bad;
            bad = 0;
            local_init_done = 1'b0;
            wb_adr_i = 32'h0000_0404; wb_dat_i = 32'h11223344; wb_sel_i = 4'h3;
            wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
            repeat (10) begin
                step(1);
                if (o.wreq || o.rreq || o.bb || o.ack) bad++;
            end
            check("init_stall_no_req", bad, 0);
            local_init_done = 1'b1;
            step(1);
            check("init_wreq_next", {o.wreq, o.bb}, 2'b11);
            local_ready = 1'b1;
            step(1);
            local_ready = 1'b0;
            check("init_ack", o.ack, 1'b1);
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            step(1);
            check("init_ack_single", o.ack, 1'b0);
        end

        // ---- cyc drops during RD_WAIT: late beat gives no ack ----
        begin
            int acks;
            acks = 0;
            wb_adr_i = 32'h0000_3000; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
            step(1);
            check("abort_rreq", o.rreq, 1'b1);
            local_ready = 1'b1;
            step(1);
            local_ready = 1'b0;
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            step(2);
            local_rdata = 32'h55AA55AA; local_rdata_valid = 1'b1;
            step(1);
            local_rdata_valid = 1'b0;
            repeat (3) begin
                if (o.ack || o.err) acks++;
                step(1);
            end
            check("abort_no_ack", acks, 0);
            check("abort_dat_unchanged", o.dat, exp_dat_a);
            run_txn(1'b1, 32'h0000_0010, 32'h77777777, 4'hF, 0, 0, 32'h0, 0);
            check("abort_recover_ack", r_ack_cyc, 2);
        end

        // ---- read timeout on instance B (RD_TIMEOUT = 4) ----
        sel_b = 1'b1;
        step(1);
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 32'h0, 0);
        check("to_err_cycle", r_err_cyc, 6);
        check("to_err_single", r_errs, 1);
        check("to_no_ack", r_acks, 0);
        local_rdata = 32'hAAAA5555; local_rdata_valid = 1'b1;
        step(1);
        local_rdata_valid = 1'b0;
        check("late_beat_no_ack", o.ack, 1'b0);
        step(1);
        check("late_beat_dat", o.dat, 32'h0);
        run_txn(1'b0, 32'h0000_0200, 32'h0, 4'hF, 0, 2, 32'h0BADF00D, 0);
        check("after_to_ack_cycle", r_ack_cyc, 4);
        check("after_to_dat", r_dat, 32'h0BADF00D);

        // second timeout, then a read whose first beat is the stale one
        run_txn(1'b0, 32'h0000_0300, 32'h0, 4'hF, 1, 0, 32'h0, 0);
        check("to2_err_cycle", r_err_cyc, 7);
        run_txn(1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, 3, 32'h600DCAFE, 1);
        check("drop_in_read_ack", {r_acks[7:0], 24'(r_ack_cyc)}, {8'd1, 24'd5});
        check("drop_in_read_dat", r_dat, 32'h600DCAFE);
        sel_b = 1'b0;
        step(1);

        // ---- reset asserted during WR_REQ ----
        wb_adr_i = 32'h0000_1C08; wb_dat_i = 32'hDEADBEEF; wb_sel_i = 4'hF;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        step(1);
        check("rst_mid_wreq_before", o.wreq, 1'b1);
        #2 reset_n = 1'b0;
        #1 check("rst_mid_outputs", o, rst_exp);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(1);
        run_txn(1'b1, 32'h0000_0020, 32'h12121212, 4'hC, 0, 0, 32'h0, 0);
        check("rst_recover_ack", r_ack_cyc, 2);
        check("rst_recover_dat", r_dat, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
